// File: rtl/m_decode_pipe_if.sv
// Handshake and decoded-bundle signals between an instruction source, the
// decode stage and its consumer.
interface m_decode_pipe_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              w_flush;
    logic              w_in_valid;
    logic              w_in_ready;
    logic [31:0]       w_ir;
    logic              w_out_valid;
    logic              w_out_ready;
    logic [5:0]        w_op;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [4:0]        w_shamt;
    logic [5:0]        w_funct;
    logic [DATA_W-1:0] w_ext;
    logic [25:0]       w_jtgt;
    logic [1:0]        w_fmt;
    logic              w_illegal;
    logic [CNT_W-1:0]  w_count;

    modport master (
        output w_flush, w_in_valid, w_ir, w_out_ready,
        input  w_in_ready, w_out_valid, w_op, w_rs, w_rt, w_rd, w_shamt,
               w_funct, w_ext, w_jtgt, w_fmt, w_illegal, w_count
    );

    modport slave (
        input  w_flush, w_in_valid, w_ir, w_out_ready,
        output w_in_ready, w_out_valid, w_op, w_rs, w_rt, w_rd, w_shamt,
               w_funct, w_ext, w_jtgt, w_fmt, w_illegal, w_count
    );
endinterface

// File: rtl/m_decode_pipe.sv
// Single-register MIPS-style decode stage: splits the instruction word into
// fields, classifies the format and extends the immediate, with valid/ready flow.
module m_decode_pipe #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic          w_clk,
    input  logic          w_rst,
    m_decode_pipe_if.slave bus
);
    localparam logic [1:0] FMT_R   = 2'b00;
    localparam logic [1:0] FMT_I   = 2'b01;
    localparam logic [1:0] FMT_J   = 2'b10;
    localparam logic [1:0] FMT_ILL = 2'b11;

    logic              r_valid;
    logic [31:0]       r_ir;
    logic [1:0]        r_fmt;
    logic [DATA_W-1:0] r_ext;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_count;

    logic [5:0]        ir_op;
    logic [1:0]        nxt_fmt;
    logic [DATA_W-1:0] nxt_ext;
    logic              accept;

    assign ir_op = bus.w_ir[31:26];

    // Ready is also held low while reset is asserted so nothing is taken early.
    assign bus.w_in_ready = (!r_valid || bus.w_out_ready) && !bus.w_flush && !w_rst;
    assign accept         = bus.w_in_valid && bus.w_in_ready;

    always_comb begin
        nxt_fmt = FMT_ILL;
        case (ir_op)
            6'h00:        nxt_fmt = FMT_R;
            6'h02, 6'h03: nxt_fmt = FMT_J;
            6'h04, 6'h05, 6'h08, 6'h09, 6'h0a,
            6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b:
                          nxt_fmt = FMT_I;
            default:      nxt_fmt = FMT_ILL;
        endcase
    end

    // Logical immediates zero-extend; lui places imm in the upper half first.
    always_comb begin
        nxt_ext = DATA_W'($signed(bus.w_ir[15:0]));
        case (ir_op)
            6'h0c, 6'h0d: nxt_ext = DATA_W'(bus.w_ir[15:0]);
            6'h0f:        nxt_ext = DATA_W'($signed({bus.w_ir[15:0], 16'h0000}));
            default:      nxt_ext = DATA_W'($signed(bus.w_ir[15:0]));
        endcase
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_valid   <= 1'b0;
            r_ir      <= '0;
            r_fmt     <= '0;
            r_ext     <= '0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            if (bus.w_flush) begin
                r_valid <= 1'b0;
            end else if (accept) begin
                r_valid <= 1'b1;
                r_ir    <= bus.w_ir;
                r_fmt   <= nxt_fmt;
                r_ext   <= nxt_ext;
                r_count <= r_count + CNT_W'(1);
                if (nxt_fmt == FMT_ILL) begin
                    r_illegal <= 1'b1;
                end
            end else if (bus.w_out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.w_out_valid = r_valid;
    assign bus.w_op        = r_ir[31:26];
    assign bus.w_rs        = r_ir[25:21];
    assign bus.w_rt        = r_ir[20:16];
    assign bus.w_rd        = r_ir[15:11];
    assign bus.w_shamt     = r_ir[10:6];
    assign bus.w_funct     = r_ir[5:0];
    assign bus.w_jtgt      = r_ir[25:0];
    assign bus.w_fmt       = r_fmt;
    assign bus.w_ext       = r_ext;
    assign bus.w_illegal   = r_illegal;
    assign bus.w_count     = r_count;
endmodule
